// File: rtl/pipe_chain_pkg.sv
// Shared types, widths and helpers for the pipe_chain stage fabric.
// Holds the stage record, perf counter width and the occupancy popcount.
package pipe_chain_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int MAX_STAGES = 16;
  localparam int PERF_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] data;
  } stage_t;

  // Sized for the widest legal chain; callers zero-extend their valid vector.
  function automatic logic [4:0] popcount(input logic [MAX_STAGES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data register of the chain; the register itself is the only latency.
// Holds while the downstream stage is stalled and it is occupied; flush clears only the next valid.
module pipe_stage #(
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev_data,
  output logic              valid,
  output logic              valid_nxt,
  output logic [DATA_W-1:0] data,
  output logic              rdy_out
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    rdy_out = rdy_in | ~valid_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy_out) begin
      valid_d = prev_valid;
      // Bubbles leave the data register untouched.
      if (prev_valid) begin
        data_d = prev_data;
      end
    end
    valid_d = valid_d & ~flush;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid     = valid_q;
  assign valid_nxt = valid_d;
  assign data      = data_q;

endmodule

// File: rtl/pipe_chain.sv
// STAGES-deep valid/ready register chain with bubble collapsing, flush mask and occupancy; STAGES cycles latency.
// Ready ripples back combinationally (pass-through ready); PIPE_CHAIN_PERF_EN adds stall/bubble counters.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 4,
  parameter int CNT_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [STAGES-1:0] flush_mask,
`ifdef PIPE_CHAIN_PERF_EN
  input  logic              perf_clr,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt,
`endif
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  occupancy
);

  logic [STAGES-1:0] v, v_nxt;
  logic [CNT_W-1:0]  occupancy_q, occupancy_d;

  // Per-stage nets live inside the generate scope so the ready ripple is not one looped vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic              rdy_i, rdy_o, pv_i, v_o, vn_o;
    logic [DATA_W-1:0] pd_i, d_o;

    if (i == 0) begin : g_head
      assign pv_i = in_valid;
      assign pd_i = in_data;
    end else begin : g_link
      assign pv_i = g_stage[i-1].v_o;
      assign pd_i = g_stage[i-1].d_o;
    end

    if (i == STAGES - 1) begin : g_tail
      assign rdy_i = out_ready;
    end else begin : g_mid
      assign rdy_i = g_stage[i+1].rdy_o;
    end

    pipe_stage #(.DATA_W(DATA_W)) u_stage (
      .CLK        (CLK),
      .nRST       (nRST),
      .rdy_in     (rdy_i),
      .flush      (flush_mask[i]),
      .prev_valid (pv_i),
      .prev_data  (pd_i),
      .valid      (v_o),
      .valid_nxt  (vn_o),
      .data       (d_o),
      .rdy_out    (rdy_o)
    );

    assign v[i]     = v_o;
    assign v_nxt[i] = vn_o;
  end

  always_comb begin
    occupancy_d = CNT_W'(popcount(MAX_STAGES'(v_nxt)));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign in_ready    = g_stage[0].rdy_o;
  assign out_valid   = v[STAGES-1];
  assign out_data    = g_stage[STAGES-1].d_o;
  assign stage_valid = v;
  assign occupancy   = occupancy_q;

`ifdef PIPE_CHAIN_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q + PERF_W'(out_valid & ~out_ready);
    bubble_cnt_d = bubble_cnt_q + PERF_W'(~out_valid & (occupancy_q != '0));
    if (perf_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised successor to the fixed IF/ID/EX/MEM/WB pipeline registers.
- Provides a STAGES-deep chain of payload registers, each with a valid bit.
- Supports valid/ready backpressure with bubble collapsing, a per-stage flush mask and a registered occupancy count.
- Intended as the common stage fabric for the next-generation datapath: hazard/branch logic drives the flush mask, and the cache hit signals drive the ready path.

Parameters:
- DATA_W, 64, payload bits carried per stage (control word + instr + pc + operands packed by user).
- STAGES, 4, number of register stages; legal range 1..16.
- CNT_W, 5, width of the occupancy output; must satisfy 2^CNT_W > STAGES.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  chain accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  last stage holds a valid payload.
- out_ready  in  1  downstream consumes the last stage this cycle.
- out_data  out  DATA_W  last-stage payload.
- flush_mask  in  STAGES  bit i kills the contents of stage i (bit 0 = first stage).
- stage_valid  out  STAGES  registered valid bit of each stage.
- occupancy  out  CNT_W  registered count of valid stages.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, on ports CLK and nRST as named above.
- Reset state: all stage valids 0, all stage data 0, occupancy 0, out_valid 0, out_data 0. in_ready is therefore 1 out of reset.
- Per-stage ready:
  - rdy[STAGES-1] = out_ready | ~v[STAGES-1].
  - rdy[i] = rdy[i+1] | ~v[i].
  - This is combinational; in_ready = rdy[0].
  - Result: a bubble anywhere lets upstream stages advance (bubble collapsing).
- Stage update on each CLK edge:
  - If rdy[i]: stage i loads the previous stage's valid and data. Stage 0 loads in_valid/in_data.
  - Otherwise stage i holds.
  - Data is loaded only when the incoming valid is 1, so data registers do not toggle on bubbles.
- Flush:
  - The next valid of stage i is computed as above, then ANDed with ~flush_mask[i].
  - A payload moving into a flushed stage in the same cycle is discarded.
  - A payload leaving a flushed stage in the same cycle still advances normally. Flush applies only to the stage's next state.
  - Flush never changes the ready computation of the current cycle.
- Handshake:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - out_valid and out_data come directly from the last stage's registers.
  - in_valid may drop without a transfer; no protocol obligation upstream.
- Latency:
  - With no stalls, a payload accepted at edge t is on out_data after edge t+STAGES-1. That is, STAGES cycles from in_valid to out_valid.
  - Full throughput is 1 payload per cycle.
- Full: all stages valid and out_ready = 0 gives in_ready = 0. Asserting out_ready makes in_ready = 1 in the same cycle (pass-through ready).
- Empty: no stage valid gives out_valid = 0 and in_ready = 1.
- occupancy:
  - Registered as the popcount of the next-state valid vector, so it matches stage_valid on every cycle.
  - Never exceeds STAGES.
- Reset mid-operation: all contents are dropped immediately (asynchronous), with no drain.

Optional Feature:
- PIPE_CHAIN_PERF_EN, when defined:
  - Adds output stall_cnt (32 bits): increments every cycle with out_valid & ~out_ready.
  - Adds output bubble_cnt (32 bits): increments every cycle with ~out_valid & (occupancy != 0).
  - Adds input perf_clr (1 bit): synchronous clear of both counters; clear wins over increment.
  - Both counters wrap from 32'hFFFFFFFF to 0 and reset to 0.
- When not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package pipe_chain_pkg:
  - Typedef stage_t (struct: logic valid, logic [DATA_W-1:0] data).
  - Localparam PERF_W = 32.
  - Function popcount for occupancy.
- One sub-module, pipe_stage:
  - Single valid+data register with rdy_in, flush, prev-stage inputs.
  - Produces its own valid, data and rdy_out.
  - pipe_chain instantiates it STAGES times in a generate loop.

Test Plan:
- Reset then stream: STAGES=4, in_valid=1, out_ready=1, in_data=1,2,3,4,5 on consecutive cycles.
  - Required: out_valid first high in cycle 4 with out_data=1, then 2..5 back to back.
  - Required: in_ready stays 1 throughout.
- Backpressure fill: out_ready=0, send 6 payloads 0xA0..0xA5.
  - Required: first 4 accepted; in_ready=0 from cycle 4; occupancy=4; out_data=0xA0 held.
  - Raise out_ready: 0xA0..0xA3 drain in order, then 0xA4/0xA5 follow with no loss or duplication.
- Bubble collapse: send 0x11, idle 2 cycles, send 0x22, with out_ready=0.
  - Required: both reach stages 3 and 2; stage_valid=4'b1100; occupancy=2.
- Flush: chain full with 0x31..0x34, flush_mask=4'b0110 for one cycle, out_ready=0.
  - Required: stage_valid=4'b1001 next cycle; occupancy=2.
  - On drain, output sequence is 0x31 then 0x34.
- Async reset mid-stream: assert nRST=0 between edges while full.
  - Required: stage_valid=0, out_valid=0 and occupancy=0 immediately; in_ready=1.
  - After release, first new payload appears after 4 cycles.
- PIPE_CHAIN_PERF_EN: hold out_valid with out_ready=0 for 10 cycles.
  - Required: stall_cnt=10.
  - Preload near wrap: 32'hFFFFFFFF -> 0.
  - perf_clr together with a stall cycle gives 0.
